alu_req_sched: RTL
==================

# alu_req_sched

Two-port request scheduler for the shared `RegFile_Alu` datapath. Two independent requesters submit ALU commands (opcode, destination register, source register or immediate) over valid/ready handshakes. The block arbitrates between them and drives the `RegFile_Alu` control inputs for exactly one enabled cycle per command. It then captures `RdestOut` and `Flags` and returns them to the winning requester over a held response handshake. It replaces hard-wired demo sequencing as the only owner of the datapath control pins.

## Interface
Parameters:
- `DATA_W`, 16, datapath width (Imm, RdestOut, response data)
- `FLAG_W`, 5, width of ALU flags
- `REG_AW`, 4, register-address width (16 registers)

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge
- `Rst`  in  1  synchronous, active-low reset (sampled on rising `Clk`)
- `req_valid_a`, `req_valid_b`  in  1  command present at port A / B
- `req_ready_a`, `req_ready_b`  out  1  port accepts command this cycle
- `req_op_a/_b`  in  4  ALU opcode
- `req_rdest_a/_b`, `req_rsrc_a/_b`  in  REG_AW  destination / source register
- `req_imm_a/_b`  in  DATA_W  immediate
- `req_imm_s_a/_b`  in  1  1 = use immediate as second operand
- `rsp_valid_a`, `rsp_valid_b`  out  1  result pending for port A / B
- `rsp_ready_a`, `rsp_ready_b`  in  1  requester consumes result
- `rsp_data`  out  DATA_W  result (shared bus, qualified by rsp_valid_x)
- `rsp_flags`  out  FLAG_W  captured flags (shared bus)
- `alu_rdest`, `alu_rsrc`  out  REG_AW  to RegFile_Alu RdestRegLoc / RsrcRegLoc
- `alu_op`  out  4  to OpCode
- `alu_imm`  out  DATA_W  to Imm
- `alu_imm_s`, `alu_en`  out  1  to Imm_s / En
- `alu_result`  in  DATA_W  from RdestOut
- `alu_flags`  in  FLAG_W  from Flags

## Operation
- State machine, all outputs registered:
  - IDLE: `req_ready_a/_b` = 1 only for the arbitration winner. On an accept, latch the command fields and the owner ID, then go to ISSUE.
  - ISSUE: drive the latched fields on `alu_*` with `alu_en`=1 for exactly this cycle, then go to CAPTURE.
  - CAPTURE: `alu_en`=0 and `alu_rdest` held. Register `alu_result`→`rsp_data` and `alu_flags`→`rsp_flags`, then go to RESP.
  - RESP: `rsp_valid_<owner>`=1. When `rsp_ready_<owner>`=1, go to IDLE.
- Arbitration: default is round-robin. A last-grant pointer resets to B, so A wins the first simultaneous request. The pointer updates on each accept.
- Only one command is in flight; no pipelining. Both `req_ready` are 0 outside IDLE.
- A single requester with the other idle is always granted, regardless of the pointer.
- Fields are latched at accept. Requester inputs may change afterward without effect.
- `rsp_data`/`rsp_flags` hold their values through RESP and until the next CAPTURE.
- The non-owner `rsp_valid` is never asserted. A `rsp_ready` from the non-owner is ignored.

## Timing
- Accept in cycle N (valid & ready high at edge N):
  - `alu_en`=1 during N+1
  - register written at edge N+1
  - result captured at edge N+2
  - `rsp_valid` high from N+3
- Minimum command-to-command spacing is 4 cycles (accept, ISSUE, CAPTURE, RESP with ready=1 immediately). Next accept is possible in the cycle after the response handshake.
- Reset (`Rst`=0 at an edge), from any state: state=IDLE, all `alu_*`=0, `alu_en`=0, `rsp_valid_*`=0, `rsp_data`=0, `rsp_flags`=0, pointer=B.
  - `req_ready_*`=0 while `Rst`=0.
  - A command in ISSUE at reset is abandoned: `alu_en` is low after that edge. No response is ever issued for it.
- `req_ready_*` is combinational from state, `req_valid_*`, and pointer. No input→output path exists through the datapath pins.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN`
  - Defined: port A has strict priority whenever `req_valid_a`=1. The pointer is not instantiated.
  - Undefined: round-robin as above.

## Test plan
- Reset, then A: ADD R0,#1 (`imm_s`=1) → `alu_en` high exactly one cycle at N+1; `rsp_valid_a` at N+3 with `rsp_data`=0x0001.
- A and B both valid after reset: A ADD R0,#1, B ADD R1,#1 → A is served first, then B; `rsp_data`=0x0001 for each. Third pair of simultaneous requests → A served first again (alternation).
- Fibonacci: alternate ADD R0,R1 / ADD R1,R0 from R0=R1=1 → responses 2, 3, 5, 8, 13.
- Backpressure: hold `rsp_ready_a`=0 for 5 cycles → `rsp_valid_a`, `rsp_data` stable; `req_ready_*`=0 throughout; B held off until the handshake.
- `Rst`=0 asserted during ISSUE → `alu_en`=0 next cycle; no `rsp_valid`; next command after reset completes normally.
- With `ALU_SCHED_FIXED_PRIO_EN`: A and B continuously valid → A is granted every time; B is granted only once A drops valid.

Source files
------------

// File: rtl/alu_req_sched.sv
// alu_req_sched: two-port valid/ready scheduler that owns the RegFile_Alu
// control pins. One command is in flight at a time. The command goes
// through ACCEPT -> ISSUE (alu_en pulse) -> CAPTURE -> RESP (held handshake).
// Optional build macro: ALU_SCHED_FIXED_PRIO_EN. When it is defined, port A
// has strict priority. When it is undefined, a last-grant pointer gives
// round-robin arbitration.
module alu_req_sched #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5,
  parameter int REG_AW = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid_a,
  input  logic              req_valid_b,
  output logic              req_ready_a,
  output logic              req_ready_b,
  input  logic [3:0]        req_op_a,
  input  logic [3:0]        req_op_b,
  input  logic [REG_AW-1:0] req_rdest_a,
  input  logic [REG_AW-1:0] req_rdest_b,
  input  logic [REG_AW-1:0] req_rsrc_a,
  input  logic [REG_AW-1:0] req_rsrc_b,
  input  logic [DATA_W-1:0] req_imm_a,
  input  logic [DATA_W-1:0] req_imm_b,
  input  logic              req_imm_s_a,
  input  logic              req_imm_s_b,
  output logic              rsp_valid_a,
  output logic              rsp_valid_b,
  input  logic              rsp_ready_a,
  input  logic              rsp_ready_b,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [REG_AW-1:0] alu_rdest,
  output logic [REG_AW-1:0] alu_rsrc,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_imm,
  output logic              alu_imm_s,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t              state_q;
  logic                owner_q;      // 0 = port A, 1 = port B
  logic [REG_AW-1:0]   alu_rdest_q;
  logic [REG_AW-1:0]   alu_rsrc_q;
  logic [3:0]          alu_op_q;
  logic [DATA_W-1:0]   alu_imm_q;
  logic                alu_imm_s_q;
  logic                alu_en_q;
  logic                rsp_valid_a_q;
  logic                rsp_valid_b_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [FLAG_W-1:0]   rsp_flags_q;
  logic                grant_a;
  logic                grant_b;
  logic                accept_a;
  logic                accept_b;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  // Strict priority: A wins whenever it is valid.
  always_comb begin
    grant_a = req_valid_a;
    grant_b = req_valid_b & ~req_valid_a;
  end
`else
  logic ptr_q;  // last grant: 0 = A, 1 = B

  // Round-robin: a lone requester always wins; on contention the port not granted last wins.
  always_comb begin
    grant_a = req_valid_a & (~req_valid_b | ptr_q);
    grant_b = req_valid_b & ~grant_a;
  end

  // Last-grant pointer moves on every accept; reset points at B so A wins first.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ptr_q <= 1'b1;
    end else if (accept_a) begin
      ptr_q <= 1'b0;
    end else if (accept_b) begin
      ptr_q <= 1'b1;
    end
  end
`endif

  // Ready is offered only in IDLE, only to the winner, and never during reset.
  assign req_ready_a = Rst & (state_q == S_IDLE) & grant_a;
  assign req_ready_b = Rst & (state_q == S_IDLE) & grant_b;
  assign accept_a    = req_valid_a & req_ready_a;
  assign accept_b    = req_valid_b & req_ready_b;

  // Command FSM: latch at accept, pulse alu_en once, capture result, hold response.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      alu_rdest_q   <= '0;
      alu_rsrc_q    <= '0;
      alu_op_q      <= '0;
      alu_imm_q     <= '0;
      alu_imm_s_q   <= 1'b0;
      alu_en_q      <= 1'b0;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_a) begin
            owner_q     <= 1'b0;
            alu_rdest_q <= req_rdest_a;
            alu_rsrc_q  <= req_rsrc_a;
            alu_op_q    <= req_op_a;
            alu_imm_q   <= req_imm_a;
            alu_imm_s_q <= req_imm_s_a;
            alu_en_q    <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (accept_b) begin
            owner_q     <= 1'b1;
            alu_rdest_q <= req_rdest_b;
            alu_rsrc_q  <= req_rsrc_b;
            alu_op_q    <= req_op_b;
            alu_imm_q   <= req_imm_b;
            alu_imm_s_q <= req_imm_s_b;
            alu_en_q    <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The register file writes on this edge; rdest stays put for the read-back.
          alu_en_q <= 1'b0;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_data_q    <= alu_result;
          rsp_flags_q   <= alu_flags;
          rsp_valid_a_q <= ~owner_q;
          rsp_valid_b_q <= owner_q;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's ready completes the response.
          if (owner_q ? rsp_ready_b : rsp_ready_a) begin
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_rdest   = alu_rdest_q;
  assign alu_rsrc    = alu_rsrc_q;
  assign alu_op      = alu_op_q;
  assign alu_imm     = alu_imm_q;
  assign alu_imm_s   = alu_imm_s_q;
  assign alu_en      = alu_en_q;
  assign rsp_valid_a = rsp_valid_a_q;
  assign rsp_valid_b = rsp_valid_b_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;

endmodule
